ext_unit: RTL and testbench
===========================

# ext_unit

Registered, parametrised immediate/data extender with valid/ready flow control, replacing the purely combinational sign extender in the fetch/decode datapath. It takes an IN-bit field and produces an OUT-bit word in one of four extension modes: sign, zero, upper-immediate, or branch offset. The result is registered, and an optional skid buffer holds one extra result so that downstream backpressure never creates a combinational ready path. It sits between instruction decode and the execute-stage operand mux.

## Interface
- IN, 16, input field width; legal range 2 to OUT-2.
- OUT, 32, output word width.
- clk_i  in  1  clock; all logic is clocked on the rising edge.
- rst_n_i  in  1  reset; synchronous, active-low.
- valid_i  in  1  an upstream item is present on d_i/mode_i.
- ready_o  out  1  the block can accept an item this cycle.
- d_i  in  IN  input field.
- mode_i  in  2  extension mode: 00 sign, 01 zero, 10 upper, 11 branch.
- valid_o  out  1  d_o holds a valid result.
- ready_i  in  1  downstream accepts d_o this cycle.
- d_o  out  OUT  extended result.

## Operation
- Accept: valid_i && ready_o at a rising edge. Deliver: valid_o && ready_i at a rising edge.
- Mode 00 (sign): the upper OUT-IN bits are copies of d_i[IN-1]; the low bits are d_i.
- Mode 01 (zero): the upper OUT-IN bits are 0; the low bits are d_i.
- Mode 10 (upper): d_i occupies bits [OUT-1:OUT-IN]; all lower bits are 0.
- Mode 11 (branch): take the sign-extended value and shift it left by 2 within OUT bits. The 2 LSBs are 0 and the top 2 bits of the sign-extended value are discarded.
- The extension is computed combinationally on accept and stored in a register. mode_i is sampled only on accept.
- Storage is a main register plus a skid register. The state is derived from two valid flags.
  - EMPTY: main invalid.
  - ONE: main valid, skid invalid.
  - FULL: both valid.
- ready_o = !skid_valid. It is a pure register output, with no combinational path from ready_i.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + deliver, no accept -> EMPTY.
  - ONE + accept + deliver -> ONE; main is reloaded with the new item.
  - ONE + accept, no deliver -> FULL; the new item goes to skid.
  - FULL + deliver -> ONE; skid moves to main. No accept is possible in FULL.
- Ordering is strictly FIFO; no item is dropped or duplicated.
- d_o is held stable while valid_o && !ready_i.

## Timing
- Latency: an item accepted at edge N appears on d_o/valid_o after edge N, so it is deliverable at edge N+1.
- Throughput: one item per cycle with ready_i held high.
- Reset, evaluated at the edge where rst_n_i=0: valid_o=0, d_o=0, skid cleared, ready_o=1 after that edge.
- Reset mid-operation: any pending main or skid item is discarded, and inputs at that edge are ignored.
- Simultaneous accept and deliver in ONE: the old item is delivered and the new item lands in main in the same edge, with no bubble.
- valid_o does not depend combinationally on valid_i.

## Configuration
- EXT_UNIT_SKID_EN defined: two-entry behaviour as described above; ready_o is independent of ready_i.
- EXT_UNIT_SKID_EN undefined: the skid register is removed and there is a single register.
  - ready_o = !valid_o || ready_i; this combinational path is permitted.
  - The FULL state does not exist.
  - Latency, reset values and ordering are unchanged.

## Test plan
- Modes with IN=16, OUT=32 and ready_i=1, using d_i=0x8001:
  - mode 00 -> 0xFFFF8001.
  - mode 01 -> 0x00008001.
  - mode 10 -> 0x80010000.
  - mode 11 -> 0xFFFE0004.
  - Each result appears one cycle after its accept.
- Positive value, d_i=0x7FFF: mode 00 -> 0x00007FFF; mode 11 -> 0x0001FFFC.
- Backpressure, ready_i=0, offering 0x0001, 0x0002, 0x0003 back-to-back:
  - 0x0001 and 0x0002 are accepted, then ready_o=0 and 0x0003 is held.
  - After ready_i=1, the outputs are 0x0001, 0x0002, 0x0003 in order.
  - d_o is stable while stalled.
- Streaming: 100 random items with random valid_i/ready_i.
  - Output sequence equals the reference model with no loss or duplication.
  - Throughput is 1 per cycle when both are held high.
- Reset in FULL: rst_n_i=0 for one edge -> valid_o=0, d_o=0, ready_o=1. No stale items appear afterwards.
- Build without EXT_UNIT_SKID_EN: repeat the backpressure scenario.
  - Only 0x0001 is accepted while stalled.
  - ready_o follows ready_i when valid_o=1.

Source files
------------

// File: rtl/ext_unit_if.sv
// -----------------------------------------------------------------------------
// ext_unit_if
// Handshake bundle for the immediate/data extender.
//   Upstream side : valid_i, d_i, mode_i (to the extender), ready_o (back)
//   Downstream    : valid_o, d_o (from the extender), ready_i (back)
// Modports:
//   slave  - the extender itself
//   master - the environment driving items in and draining results
// Parameters: IN (input field width), OUT (output word width).
// -----------------------------------------------------------------------------
interface ext_unit_if #(
  parameter int IN  = 16,
  parameter int OUT = 32
);
  logic           valid_i;
  logic           ready_o;
  logic [IN-1:0]  d_i;
  logic [1:0]     mode_i;
  logic           valid_o;
  logic           ready_i;
  logic [OUT-1:0] d_o;

  modport slave (
    input  valid_i,
    input  d_i,
    input  mode_i,
    input  ready_i,
    output ready_o,
    output valid_o,
    output d_o
  );

  modport master (
    output valid_i,
    output d_i,
    output mode_i,
    output ready_i,
    input  ready_o,
    input  valid_o,
    input  d_o
  );
endinterface

// File: rtl/ext_unit.sv
// -----------------------------------------------------------------------------
// ext_unit
// Registered immediate/data extender with valid/ready flow control. Sits between
// instruction decode and the execute-stage operand mux. Each accepted IN-bit
// field is extended to OUT bits in one of four modes and stored in a register:
//   mode 00 sign   : sign-extend d_i
//   mode 01 zero   : zero-extend d_i
//   mode 10 upper  : d_i in the top IN bits, zeros below
//   mode 11 branch : sign-extend d_i, then shift left by 2 within OUT bits
//
// Ports:
//   clk_i    in  1   clock, rising edge
//   rst_n_i  in  1   synchronous active-low reset
//   bus      ext_unit_if.slave
//            valid_i/ready_o/d_i/mode_i : upstream handshake and item
//            valid_o/ready_i/d_o        : downstream handshake and result
//
// Build option:
//   EXT_UNIT_SKID_EN defined   : main + skid register; ready_o is a pure
//                                register output (no path from ready_i).
//   EXT_UNIT_SKID_EN undefined : single register; ready_o = !valid_o || ready_i.
//
// Parameters: IN (legal range 2 .. OUT-2), OUT.
// -----------------------------------------------------------------------------
module ext_unit #(
  parameter int IN  = 16,
  parameter int OUT = 32
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  ext_unit_if.slave  bus
);

  // State encoding doubles as the valid flags: bit0 = main valid, bit1 = skid
  // valid. FULL is never entered when the skid register is not built.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [OUT-1:0] r_main;
  logic [OUT-1:0] w_ext;
  logic [OUT-1:0] w_main_src;
  logic           w_accept;
  logic           w_deliver;
  logic           w_ready;
  logic           w_main_ld;
`ifdef EXT_UNIT_SKID_EN
  logic [OUT-1:0] r_skid;
  logic           w_skid_ld;
  logic           w_main_from_skid;
`endif

  // Extension of one field; branch mode reuses the sign-extended value and the
  // left shift drops its top two bits naturally at OUT width.
  function automatic logic [OUT-1:0] ext_fn(input logic [IN-1:0] d,
                                            input logic [1:0]    mode);
    logic [OUT-1:0] sx;
    sx = {{(OUT-IN){d[IN-1]}}, d};
    case (mode)
      2'b00:   ext_fn = sx;
      2'b01:   ext_fn = {{(OUT-IN){1'b0}}, d};
      2'b10:   ext_fn = {d, {(OUT-IN){1'b0}}};
      2'b11:   ext_fn = sx << 2'd2;
      default: ext_fn = {OUT{1'b0}};
    endcase
  endfunction

  assign w_ext = ext_fn(bus.d_i, bus.mode_i);

`ifdef EXT_UNIT_SKID_EN
  // Ready only depends on the registered skid flag.
  assign w_ready = ~r_state[1];
`else
  // Single register: a slot frees up in the same cycle the result leaves.
  assign w_ready = ~r_state[0] | bus.ready_i;
`endif

  assign w_accept  = bus.valid_i & w_ready;
  assign w_deliver = r_state[0] & bus.ready_i;

  assign bus.ready_o = w_ready;
  assign bus.valid_o = r_state[0];
  assign bus.d_o     = r_main;

`ifdef EXT_UNIT_SKID_EN
  assign w_main_src = w_main_from_skid ? r_skid : w_ext;
`else
  assign w_main_src = w_ext;
`endif

  // Next-state and register-load decode.
  always_comb begin
    w_state_nxt = r_state;
    w_main_ld   = 1'b0;
`ifdef EXT_UNIT_SKID_EN
    w_skid_ld        = 1'b0;
    w_main_from_skid = 1'b0;
`endif
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_main_ld   = 1'b1;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (w_accept && w_deliver) begin
          // Old item leaves while the new one lands in main: no bubble.
          w_state_nxt = ST_ONE;
          w_main_ld   = 1'b1;
        end else if (w_deliver) begin
          w_state_nxt = ST_EMPTY;
`ifdef EXT_UNIT_SKID_EN
        end else if (w_accept) begin
          // main is stalled and must stay stable; park the new item.
          w_state_nxt = ST_FULL;
          w_skid_ld   = 1'b1;
`endif
        end else begin
          w_state_nxt = ST_ONE;
        end
      end
      ST_FULL: begin
`ifdef EXT_UNIT_SKID_EN
        if (w_deliver) begin
          w_state_nxt      = ST_ONE;
          w_main_ld        = 1'b1;
          w_main_from_skid = 1'b1;
        end else begin
          w_state_nxt = ST_FULL;
        end
`else
        w_state_nxt = ST_EMPTY;
`endif
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // State and main result register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= ST_EMPTY;
      r_main  <= {OUT{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_main_ld) begin
        r_main <= w_main_src;
      end
    end
  end

`ifdef EXT_UNIT_SKID_EN
  // Skid result register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_skid <= {OUT{1'b0}};
    end else if (w_skid_ld) begin
      r_skid <= w_ext;
    end
  end
`endif

endmodule

// File: tb/tb_ext_unit.sv
// -----------------------------------------------------------------------------
// tb_ext_unit
// Self-checking bench for ext_unit (IN=16, OUT=32). A mode table is applied in
// a loop; hand-written sequences cover backpressure, random streaming,
// throughput and reset while holding items. Every accept pushes a model result
// into a queue; every deliver pops and compares it.
// -----------------------------------------------------------------------------
module tb_ext_unit;
  localparam int IN  = 16;
  localparam int OUT = 32;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ext_unit_if #(.IN(IN), .OUT(OUT)) bus ();

  ext_unit #(.IN(IN), .OUT(OUT)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] sb_q[$];
  logic        last_acc;
  logic        last_del;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  m;
    logic [31:0] e;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] bp[3];

  function automatic logic [31:0] model(input logic [15:0] d, input logic [1:0] m);
    logic signed [31:0] s;
    s = $signed(d);
    case (m)
      2'b00:   return s;
      2'b01:   return {16'h0000, d};
      2'b10:   return {d, 16'h0000};
      default: return s * 32'sd4;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock: observe handshakes at negedge (scoreboard), then return #1 after posedge.
  task automatic step();
    @(negedge clk);
    last_acc = 1'b0;
    last_del = 1'b0;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (bus.valid_o && bus.ready_i) begin
        last_del = 1'b1;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got %h want none", bus.d_o);
        end else begin
          chk("sb_order", bus.d_o, sb_q.pop_front());
        end
      end
      if (bus.valid_i && bus.ready_o) begin
        last_acc = 1'b1;
        sb_q.push_back(model(bus.d_i, bus.mode_i));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int sent;
    int ndel;

    vecs[0] = '{16'h8001, 2'b00, 32'hFFFF8001};
    vecs[1] = '{16'h8001, 2'b01, 32'h00008001};
    vecs[2] = '{16'h8001, 2'b10, 32'h80010000};
    vecs[3] = '{16'h8001, 2'b11, 32'hFFFE0004};
    vecs[4] = '{16'h7FFF, 2'b00, 32'h00007FFF};
    vecs[5] = '{16'h7FFF, 2'b11, 32'h0001FFFC};
    vecs[6] = '{16'h0000, 2'b11, 32'h00000000};
    vecs[7] = '{16'hFFFF, 2'b10, 32'hFFFF0000};
    bp[0] = 16'h0001;
    bp[1] = 16'h0002;
    bp[2] = 16'h0003;

    // Reset
    rst_n       = 1'b0;
    bus.valid_i = 1'b0;
    bus.d_i     = 16'h0000;
    bus.mode_i  = 2'b00;
    bus.ready_i = 1'b1;
    step();
    step();
    chk("rst_valid_o", 32'(bus.valid_o), 32'd0);
    chk("rst_d_o", bus.d_o, 32'd0);
    chk("rst_ready_o", 32'(bus.ready_o), 32'd1);
    rst_n = 1'b1;
    step();

    // Mode table, back-to-back: each result is visible one edge after accept
    for (int i = 0; i < 8; i++) begin
      bus.valid_i = 1'b1;
      bus.d_i     = vecs[i].d;
      bus.mode_i  = vecs[i].m;
      step();
      chk("tbl_valid_o", 32'(bus.valid_o), 32'd1);
      chk("tbl_d_o", bus.d_o, vecs[i].e);
    end
    bus.valid_i = 1'b0;
    step();
    step();
    chk("tbl_drain", 32'(sb_q.size()), 32'd0);

    // Backpressure: offer 1,2,3 with ready_i low
    bus.ready_i = 1'b0;
    bus.mode_i  = 2'b01;
    idx         = 0;
    bus.valid_i = 1'b1;
    bus.d_i     = bp[0];
    for (int c = 0; c < 4; c++) begin
      step();
      if (last_acc) idx++;
      if (idx < 3) bus.d_i = bp[idx];
      else bus.valid_i = 1'b0;
      if (c > 0) chk("bp_stable", bus.d_o, 32'h00000001);
    end
`ifdef EXT_UNIT_SKID_EN
    chk("bp_accepted", 32'(idx), 32'd2);
`else
    chk("bp_accepted", 32'(idx), 32'd1);
`endif
    chk("bp_ready_low", 32'(bus.ready_o), 32'd0);
    chk("bp_valid_o", 32'(bus.valid_o), 32'd1);
    bus.ready_i = 1'b1;
    #1;
`ifdef EXT_UNIT_SKID_EN
    chk("bp_ready_indep", 32'(bus.ready_o), 32'd0);
`else
    chk("bp_ready_follows", 32'(bus.ready_o), 32'd1);
`endif
    for (int c = 0; c < 20 && idx < 3; c++) begin
      step();
      if (last_acc) idx++;
      if (idx < 3) bus.d_i = bp[idx];
      else bus.valid_i = 1'b0;
    end
    chk("bp_all_accepted", 32'(idx), 32'd3);
    bus.valid_i = 1'b0;
    repeat (3) step();
    chk("bp_drain", 32'(sb_q.size()), 32'd0);

    // Random streaming: 100 items, random valid/ready
    sent = 0;
    for (int c = 0; c < 3000 && sent < 100; c++) begin
      bus.valid_i = ($urandom_range(0, 3) != 0);
      bus.d_i     = 16'($urandom);
      bus.mode_i  = 2'($urandom_range(0, 3));
      bus.ready_i = ($urandom_range(0, 2) != 0);
      step();
      if (last_acc) sent++;
    end
    chk("rnd_sent", 32'(sent), 32'd100);
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    repeat (4) step();
    chk("rnd_drain", 32'(sb_q.size()), 32'd0);

    // Throughput: 20 cycles with both held high -> 19 deliveries in-window
    ndel        = 0;
    bus.valid_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.d_i    = 16'($urandom);
      bus.mode_i = 2'($urandom_range(0, 3));
      step();
      if (last_del) ndel++;
    end
    chk("thru_deliv", 32'(ndel), 32'd19);
    bus.valid_i = 1'b0;
    repeat (2) step();
    chk("thru_drain", 32'(sb_q.size()), 32'd0);

    // Reset while holding items (FULL with skid, ONE without)
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.mode_i  = 2'b00;
    bus.d_i     = 16'h00AA;
    step();
    bus.d_i = 16'h00BB;
    step();
    chk("full_ready_low", 32'(bus.ready_o), 32'd0);
    rst_n   = 1'b0;
    bus.d_i = 16'h00CC;
    step();
    chk("rst2_valid_o", 32'(bus.valid_o), 32'd0);
    chk("rst2_d_o", bus.d_o, 32'd0);
    chk("rst2_ready_o", 32'(bus.ready_o), 32'd1);
    rst_n       = 1'b1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    repeat (3) step();
    chk("rst2_no_stale", 32'(bus.valid_o), 32'd0);
    chk("rst2_queue", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
